// File: rtl/ex_stage_muldiv_if.sv
// Execute-stage bus: operands and control from the OF/EX register,
// plus the EX/MA register, branch redirect, flags and stall back out.
// With EX_STALL_CNT_EN defined the bus also carries stall_cycles.
interface ex_stage_muldiv_if #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 24
);
   logic [DATA_W-1:0] pc_in;
   logic [DATA_W-1:0] instruction_in;
   logic [DATA_W-1:0] A_in;
   logic [DATA_W-1:0] B_in;
   logic [DATA_W-1:0] op2_in;
   logic [CTRL_W-1:0] control_bus_in;
   logic [DATA_W-1:0] btarget_in;

   logic              stall;
   logic              branch_taken;
   logic [DATA_W-1:0] branch_pc;
   logic              flag_e;
   logic              flag_gt;
   logic [DATA_W-1:0] pc_out;
   logic [DATA_W-1:0] instruction_out;
   logic [DATA_W-1:0] aluresult_out;
   logic [DATA_W-1:0] B_out;
   logic [CTRL_W-1:0] control_bus_out;
`ifdef EX_STALL_CNT_EN
   logic [31:0]       stall_cycles;
`endif

   // Upstream side (OF/EX register / testbench)
   modport master (
      output pc_in, instruction_in, A_in, B_in, op2_in, control_bus_in, btarget_in,
      input  stall, branch_taken, branch_pc, flag_e, flag_gt,
      input  pc_out, instruction_out, aluresult_out, B_out, control_bus_out
`ifdef EX_STALL_CNT_EN
      , input stall_cycles
`endif
   );

   // Execute stage side
   modport slave (
      input  pc_in, instruction_in, A_in, B_in, op2_in, control_bus_in, btarget_in,
      output stall, branch_taken, branch_pc, flag_e, flag_gt,
      output pc_out, instruction_out, aluresult_out, B_out, control_bus_out
`ifdef EX_STALL_CNT_EN
      , output stall_cycles
`endif
   );
endinterface

// File: rtl/ex_stage_muldiv.sv
// Execute stage: ALU, flags, branch decision and the EX/MA register.
// Signed div/mod use a 32-iteration restoring divider and stall upstream.
// Optional macro EX_STALL_CNT_EN adds a saturating stall_cycles counter.
module ex_stage_muldiv #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 24
) (
   input logic              clk,
   input logic              reset,
   ex_stage_muldiv_if.slave bus
);

   localparam int CNT_W = $clog2(DATA_W);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DIV_RUN  = 2'd1,
      DIV_DONE = 2'd2
   } state_t;

   state_t            state;

   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] op2;
   logic [CTRL_W-1:0] ctrl;

   logic is_add, is_sub, is_cmp, is_mul, is_div, is_mod;
   logic is_lsl, is_lsr, is_asr, is_or, is_and, is_not, is_mov;
   logic is_beq, is_bgt, is_ret, is_ubr;

   logic [DATA_W-1:0] alu_result;
   logic              div_start;
   logic              stall;

   logic [DATA_W-1:0] div_rem;
   logic [DATA_W-1:0] div_quo;
   logic [DATA_W-1:0] div_dvs;
   logic              sign_q;
   logic              sign_r;
   logic              div_is_mod;
   logic [CNT_W-1:0]  count;

   logic [DATA_W-1:0] abs_a;
   logic [DATA_W-1:0] abs_op2;
   logic [DATA_W-1:0] rem_shift;
   logic [DATA_W:0]   rem_diff;
   logic              rem_ge;
   logic [DATA_W-1:0] div_final;

   assign a    = bus.A_in;
   assign op2  = bus.op2_in;
   assign ctrl = bus.control_bus_in;

   assign is_add = ctrl[0];
   assign is_sub = ctrl[1];
   assign is_cmp = ctrl[2];
   assign is_mul = ctrl[3];
   assign is_div = ctrl[4];
   assign is_mod = ctrl[5];
   assign is_lsl = ctrl[6];
   assign is_lsr = ctrl[7];
   assign is_asr = ctrl[8];
   assign is_or  = ctrl[9];
   assign is_and = ctrl[10];
   assign is_not = ctrl[11];
   assign is_mov = ctrl[12];
   assign is_beq = ctrl[15];
   assign is_bgt = ctrl[16];
   assign is_ret = ctrl[17];
   assign is_ubr = ctrl[20];

   // Single-cycle ALU result; divide-by-zero is resolved here without stalling
   always_comb begin
      alu_result = '0;
      if (is_add)      alu_result = a + op2;
      else if (is_sub) alu_result = a - op2;
      else if (is_cmp) alu_result = a - op2;
      else if (is_mul) alu_result = a * op2;
      else if (is_div) alu_result = (op2 == '0) ? '1 : '0;
      else if (is_mod) alu_result = (op2 == '0) ? a : '0;
      else if (is_lsl) alu_result = a << op2[4:0];
      else if (is_lsr) alu_result = a >> op2[4:0];
      else if (is_asr) alu_result = $signed(a) >>> op2[4:0];
      else if (is_or)  alu_result = a | op2;
      else if (is_and) alu_result = a & op2;
      else if (is_not) alu_result = ~op2;
      else if (is_mov) alu_result = op2;
   end

   assign div_start = (state == IDLE) && (is_div || is_mod) && (op2 != '0);
   assign stall     = div_start || (state == DIV_RUN);

   // Operand magnitudes, one restoring step, and sign-corrected final result
   always_comb begin
      abs_a     = a[DATA_W-1]   ? -a   : a;
      abs_op2   = op2[DATA_W-1] ? -op2 : op2;
      rem_shift = {div_rem[DATA_W-2:0], div_quo[DATA_W-1]};
      rem_diff  = {1'b0, rem_shift} - {1'b0, div_dvs};
      rem_ge    = ~rem_diff[DATA_W];
      if (div_is_mod) div_final = sign_r ? -div_rem : div_rem;
      else            div_final = sign_q ? -div_quo : div_quo;
   end

   assign bus.stall        = stall;
   assign bus.branch_taken = ~stall & (is_ubr | (is_beq & bus.flag_e) | (is_bgt & bus.flag_gt));
   assign bus.branch_pc    = is_ret ? a : bus.btarget_in;

   // Divider FSM, flags and EX/MA register
   always_ff @(posedge clk) begin
      if (reset) begin
         state               <= IDLE;
         count               <= '0;
         div_rem             <= '0;
         div_quo             <= '0;
         div_dvs             <= '0;
         sign_q              <= 1'b0;
         sign_r              <= 1'b0;
         div_is_mod          <= 1'b0;
         bus.flag_e          <= 1'b0;
         bus.flag_gt         <= 1'b0;
         bus.pc_out          <= '0;
         bus.instruction_out <= '0;
         bus.aluresult_out   <= '0;
         bus.B_out           <= '0;
         bus.control_bus_out <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (div_start) begin
                  div_rem    <= '0;
                  div_quo    <= abs_a;
                  div_dvs    <= abs_op2;
                  sign_q     <= a[DATA_W-1] ^ op2[DATA_W-1];
                  sign_r     <= a[DATA_W-1];
                  div_is_mod <= is_mod;
                  count      <= '0;
                  state      <= DIV_RUN;
               end
            end
            DIV_RUN: begin
               div_rem <= rem_ge ? rem_diff[DATA_W-1:0] : rem_shift;
               div_quo <= {div_quo[DATA_W-2:0], rem_ge};
               count   <= count + 1'b1;
               if (count == CNT_W'(DATA_W - 1)) state <= DIV_DONE;
            end
            DIV_DONE: state <= IDLE;
            default:  state <= IDLE;
         endcase

         if (stall) begin
            bus.pc_out          <= '0;
            bus.instruction_out <= '0;
            bus.aluresult_out   <= '0;
            bus.B_out           <= '0;
            bus.control_bus_out <= '0;
         end else begin
            bus.pc_out          <= bus.pc_in;
            bus.instruction_out <= bus.instruction_in;
            bus.aluresult_out   <= (state == DIV_DONE) ? div_final : alu_result;
            bus.B_out           <= bus.B_in;
            bus.control_bus_out <= ctrl;
         end

         if (!stall && is_cmp) begin
            bus.flag_e  <= (a == op2);
            bus.flag_gt <= ($signed(a) > $signed(op2));
         end
      end
   end

`ifdef EX_STALL_CNT_EN
   // Saturating count of cycles spent with stall asserted
   always_ff @(posedge clk) begin
      if (reset)                                  bus.stall_cycles <= '0;
      else if (stall && bus.stall_cycles != '1)   bus.stall_cycles <= bus.stall_cycles + 1'b1;
   end
`endif

endmodule

// File: tb/tb_ex_stage_muldiv.sv
// Directed self-checking bench for ex_stage_muldiv.
module tb_ex_stage_muldiv;

   localparam logic [23:0] OP_NOP = 24'h000000;
   localparam logic [23:0] OP_ADD = 24'h000001;
   localparam logic [23:0] OP_SUB = 24'h000002;
   localparam logic [23:0] OP_CMP = 24'h000004;
   localparam logic [23:0] OP_MUL = 24'h000008;
   localparam logic [23:0] OP_DIV = 24'h000010;
   localparam logic [23:0] OP_MOD = 24'h000020;
   localparam logic [23:0] OP_LSL = 24'h000040;
   localparam logic [23:0] OP_LSR = 24'h000080;
   localparam logic [23:0] OP_ASR = 24'h000100;
   localparam logic [23:0] OP_OR  = 24'h000200;
   localparam logic [23:0] OP_AND = 24'h000400;
   localparam logic [23:0] OP_NOT = 24'h000800;
   localparam logic [23:0] OP_MOV = 24'h001000;
   localparam logic [23:0] OP_BEQ = 24'h008000;
   localparam logic [23:0] OP_BGT = 24'h010000;
   localparam logic [23:0] OP_RET = 24'h020000;
   localparam logic [23:0] OP_UBR = 24'h100000;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   ex_stage_muldiv_if #(.DATA_W(32), .CTRL_W(24)) bus ();

   ex_stage_muldiv #(.DATA_W(32), .CTRL_W(24)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive(input logic [23:0] cb, input logic [31:0] a, input logic [31:0] op2,
                        input logic [31:0] b, input logic [31:0] pc, input logic [31:0] instr,
                        input logic [31:0] btgt);
      bus.control_bus_in = cb;
      bus.A_in           = a;
      bus.op2_in         = op2;
      bus.B_in           = b;
      bus.pc_in          = pc;
      bus.instruction_in = instr;
      bus.btarget_in     = btgt;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive(OP_NOP, '0, '0, '0, '0, '0, '0);
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      #1;
      n_checks++;
      if ({bus.stall, bus.branch_taken, bus.flag_e, bus.flag_gt} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b required 0000",
                  {bus.stall, bus.branch_taken, bus.flag_e, bus.flag_gt});
      end
      n_checks++;
      if ({bus.pc_out, bus.instruction_out, bus.aluresult_out, bus.B_out, bus.control_bus_out} !== '0) begin
         n_fail++;
         $display("FAIL reset_exma: got pc=%h ins=%h res=%h b=%h cb=%h required all 0",
                  bus.pc_out, bus.instruction_out, bus.aluresult_out, bus.B_out, bus.control_bus_out);
      end
   endtask

   task automatic test_cmp_branch();
      drive(OP_CMP, 32'd5, 32'd5, '0, 32'h200, 32'h22, 32'h40);
      #1;
      n_checks++;
      if (bus.branch_taken !== 1'b0) begin
         n_fail++;
         $display("FAIL cmp_no_branch: got %b required 0", bus.branch_taken);
      end
      tick();
      n_checks++;
      if ({bus.flag_e, bus.flag_gt} !== 2'b10) begin
         n_fail++;
         $display("FAIL cmp_eq_flags: got %b required 10", {bus.flag_e, bus.flag_gt});
      end
      drive(OP_BEQ, '0, '0, '0, 32'h204, 32'h23, 32'h40);
      #1;
      n_checks++;
      if ({bus.branch_taken, bus.branch_pc} !== {1'b1, 32'h40}) begin
         n_fail++;
         $display("FAIL beq_taken: got %b/%h required 1/00000040", bus.branch_taken, bus.branch_pc);
      end
      drive(OP_BGT, '0, '0, '0, 32'h204, 32'h23, 32'h40);
      #1;
      n_checks++;
      if (bus.branch_taken !== 1'b0) begin
         n_fail++;
         $display("FAIL bgt_not_taken: got %b required 0", bus.branch_taken);
      end
      drive(OP_RET | OP_UBR, 32'h1234, '0, '0, 32'h204, 32'h24, 32'h40);
      #1;
      n_checks++;
      if ({bus.branch_taken, bus.branch_pc} !== {1'b1, 32'h1234}) begin
         n_fail++;
         $display("FAIL ret_target: got %b/%h required 1/00001234", bus.branch_taken, bus.branch_pc);
      end
      tick();
      drive(OP_CMP, 32'd3, 32'hFFFFFFFF, '0, 32'h208, 32'h25, 32'h80);
      tick();
      n_checks++;
      if ({bus.flag_e, bus.flag_gt} !== 2'b01) begin
         n_fail++;
         $display("FAIL cmp_signed_gt: got %b required 01", {bus.flag_e, bus.flag_gt});
      end
      drive(OP_BGT, '0, '0, '0, 32'h20C, 32'h26, 32'h80);
      #1;
      n_checks++;
      if ({bus.branch_taken, bus.branch_pc} !== {1'b1, 32'h80}) begin
         n_fail++;
         $display("FAIL bgt_taken: got %b/%h required 1/00000080", bus.branch_taken, bus.branch_pc);
      end
      drive(OP_BEQ, '0, '0, '0, 32'h20C, 32'h26, 32'h80);
      #1;
      n_checks++;
      if (bus.branch_taken !== 1'b0) begin
         n_fail++;
         $display("FAIL beq_not_taken: got %b required 0", bus.branch_taken);
      end
      tick();
   endtask

   task automatic test_add();
      drive(OP_ADD, 32'h7FFFFFFF, 32'd1, 32'hB, 32'h100, 32'h11, '0);
      #1;
      n_checks++;
      if (bus.stall !== 1'b0) begin
         n_fail++;
         $display("FAIL add_stall: got %b required 0", bus.stall);
      end
      tick();
      n_checks++;
      if (bus.aluresult_out !== 32'h80000000) begin
         n_fail++;
         $display("FAIL add_wrap: got %h required 80000000", bus.aluresult_out);
      end
      n_checks++;
      if ({bus.pc_out, bus.instruction_out, bus.B_out, bus.control_bus_out} !==
          {32'h100, 32'h11, 32'hB, OP_ADD}) begin
         n_fail++;
         $display("FAIL add_exma: got pc=%h ins=%h b=%h cb=%h required 00000100/00000011/0000000b/000001",
                  bus.pc_out, bus.instruction_out, bus.B_out, bus.control_bus_out);
      end
      n_checks++;
      if ({bus.flag_e, bus.flag_gt} !== 2'b01) begin
         n_fail++;
         $display("FAIL add_flags_kept: got %b required 01", {bus.flag_e, bus.flag_gt});
      end
   endtask

   task automatic test_alu_ops();
      logic [23:0] cbs [10] = '{OP_SUB, OP_MUL, OP_LSL, OP_LSR, OP_ASR,
                                OP_OR, OP_AND, OP_NOT, OP_MOV, OP_NOP};
      logic [31:0] as  [10] = '{32'h0, 32'hFFFFFFFD, 32'h1, 32'h80000000, 32'h80000000,
                                32'hF0F0F0F0, 32'hF0F0F0F0, 32'h12345678, 32'h0, 32'h5};
      logic [31:0] bs  [10] = '{32'h1, 32'h5, 32'h3F, 32'h4, 32'h24,
                                32'h0F0F0F00, 32'h3C3C3C3C, 32'h0, 32'hDEADBEEF, 32'h6};
      logic [31:0] exs [10] = '{32'hFFFFFFFF, 32'hFFFFFFF1, 32'h80000000, 32'h08000000, 32'hF8000000,
                                32'hFFFFFFF0, 32'h30303030, 32'hFFFFFFFF, 32'hDEADBEEF, 32'h0};
      for (int i = 0; i < 10; i++) begin
         drive(cbs[i], as[i], bs[i], '0, 32'h300 + i, 32'h30 + i, '0);
         tick();
         n_checks++;
         if (bus.aluresult_out !== exs[i]) begin
            n_fail++;
            $display("FAIL alu_op_%0d: got %h required %h", i, bus.aluresult_out, exs[i]);
         end
      end
   endtask

   task automatic test_div(input logic [23:0] cb, input logic [31:0] a, input logic [31:0] op2,
                           input logic [31:0] expv, input string name);
      int   cycles;
      logic bubble_ok;
      drive(cb, a, op2, 32'hBB, 32'h400, 32'h44, '0);
      #1;
      n_checks++;
      if (bus.stall !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_stall_start: got %b required 1", name, bus.stall);
      end
      cycles    = 0;
      bubble_ok = 1'b1;
      while (bus.stall === 1'b1 && cycles < 100) begin
         tick();
         cycles++;
         if ({bus.pc_out, bus.instruction_out, bus.aluresult_out, bus.B_out, bus.control_bus_out} !== '0)
            bubble_ok = 1'b0;
         if (bus.branch_taken !== 1'b0) bubble_ok = 1'b0;
      end
      n_checks++;
      if (cycles != 33) begin
         n_fail++;
         $display("FAIL %s_stall_len: got %0d required 33", name, cycles);
      end
      n_checks++;
      if (bubble_ok !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_bubbles: got non-bubble required bubble", name);
      end
      tick();
      n_checks++;
      if ({bus.aluresult_out, bus.instruction_out, bus.control_bus_out} !== {expv, 32'h44, cb}) begin
         n_fail++;
         $display("FAIL %s_result: got %h/%h/%h required %h/00000044/%h",
                  name, bus.aluresult_out, bus.instruction_out, bus.control_bus_out, expv, cb);
      end
      n_checks++;
      if ({bus.flag_e, bus.flag_gt} !== 2'b01) begin
         n_fail++;
         $display("FAIL %s_flags_kept: got %b required 01", name, {bus.flag_e, bus.flag_gt});
      end
   endtask

   task automatic test_div_by_zero();
      drive(OP_DIV, 32'd9, '0, '0, 32'h500, 32'h55, '0);
      #1;
      n_checks++;
      if (bus.stall !== 1'b0) begin
         n_fail++;
         $display("FAIL divz_stall: got %b required 0", bus.stall);
      end
      tick();
      n_checks++;
      if (bus.aluresult_out !== 32'hFFFFFFFF) begin
         n_fail++;
         $display("FAIL divz_div: got %h required ffffffff", bus.aluresult_out);
      end
      drive(OP_MOD, 32'd9, '0, '0, 32'h504, 32'h56, '0);
      #1;
      n_checks++;
      if (bus.stall !== 1'b0) begin
         n_fail++;
         $display("FAIL modz_stall: got %b required 0", bus.stall);
      end
      tick();
      n_checks++;
      if (bus.aluresult_out !== 32'd9) begin
         n_fail++;
         $display("FAIL modz_mod: got %h required 00000009", bus.aluresult_out);
      end
   endtask

   task automatic test_back_to_back();
      test_div(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_min");
      test_div(OP_MOD, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, "mod_min");
      drive(OP_NOP, '0, '0, '0, '0, '0, '0);
      tick();
   endtask

   task automatic test_reset_mid_div();
      drive(OP_DIV, 32'd100, 32'd3, 32'hCC, 32'h600, 32'h66, '0);
      #1;
      repeat (9) tick();
      n_checks++;
      if (bus.stall !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_div_pre_stall: got %b required 1", bus.stall);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      drive(OP_NOP, '0, '0, '0, '0, '0, '0);
      #1;
      n_checks++;
      if ({bus.stall, bus.branch_taken, bus.flag_e, bus.flag_gt} !== 4'b0000) begin
         n_fail++;
         $display("FAIL rst_div_ctrl: got %b required 0000",
                  {bus.stall, bus.branch_taken, bus.flag_e, bus.flag_gt});
      end
      n_checks++;
      if ({bus.pc_out, bus.instruction_out, bus.aluresult_out, bus.B_out, bus.control_bus_out} !== '0) begin
         n_fail++;
         $display("FAIL rst_div_exma: got pc=%h ins=%h res=%h b=%h cb=%h required all 0",
                  bus.pc_out, bus.instruction_out, bus.aluresult_out, bus.B_out, bus.control_bus_out);
      end
      drive(OP_ADD, 32'd2, 32'd3, 32'h7, 32'h700, 32'h77, '0);
      #1;
      n_checks++;
      if (bus.stall !== 1'b0) begin
         n_fail++;
         $display("FAIL post_rst_add_stall: got %b required 0", bus.stall);
      end
      tick();
      n_checks++;
      if ({bus.aluresult_out, bus.pc_out} !== {32'd5, 32'h700}) begin
         n_fail++;
         $display("FAIL post_rst_add: got %h/%h required 00000005/00000700", bus.aluresult_out, bus.pc_out);
      end
      drive(OP_NOP, '0, '0, '0, '0, '0, '0);
      repeat (40) tick();
      n_checks++;
      if ({bus.stall, bus.aluresult_out, bus.control_bus_out} !== '0) begin
         n_fail++;
         $display("FAIL post_rst_no_stale: got stall=%b res=%h cb=%h required 0",
                  bus.stall, bus.aluresult_out, bus.control_bus_out);
      end
   endtask

   initial begin
      clk      = 1'b0;
      reset    = 1'b1;
      n_checks = 0;
      n_fail   = 0;
      drive(OP_NOP, '0, '0, '0, '0, '0, '0);

      test_reset();
      test_cmp_branch();
      test_add();
      test_alu_ops();
      test_div(OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, "div_neg7_2");
      drive(OP_NOP, '0, '0, '0, '0, '0, '0);
      tick();
      test_div(OP_MOD, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, "mod_neg7_2");
      drive(OP_NOP, '0, '0, '0, '0, '0, '0);
      tick();
      test_div_by_zero();
      test_back_to_back();
      test_reset_mid_div();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ex_stage_muldiv.md
Name: ex_stage_muldiv

Overview:
- Execute stage that sits directly downstream of the OF/EX pipeline register.
- Consumes the registered pc, instruction, A, B, op2, control bus and branch target from that register.
- Computes the ALU result, the branch decision and the flags, and holds the EX/MA pipeline register internally.
- Signed div/mod run on an iterative 32-cycle divider; the block asserts stall so the upstream stages hold.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.
- CTRL_W, 24, control bus width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- pc_in  in  32  PC of the instruction in EX
- instruction_in  in  32  raw instruction
- A_in  in  32  operand 1 (rs1 value)
- B_in  in  32  rs2/rd value, used as store data
- op2_in  in  32  operand 2 (register or immediate, already muxed)
- control_bus_in  in  24  bits [12:0] one-hot ALU op: add, sub, cmp, mul, div, mod, lsl, lsr, asr, or, and, not, mov; 13 isSt, 14 isLd, 15 isBeq, 16 isBgt, 17 isRet, 18 isImmediate, 19 isWb, 20 isUBranch, 21 isCall, [23:22] reserved
- btarget_in  in  32  precomputed branch target
- stall  out  1  upstream stages hold when 1
- branch_taken  out  1  combinational; fetch redirects and flushes when 1
- branch_pc  out  32  combinational redirect target
- flag_e  out  1  registered equal flag
- flag_gt  out  1  registered greater-than flag
- pc_out  out  32  EX/MA register
- instruction_out  out  32  EX/MA register
- aluresult_out  out  32  EX/MA register
- B_out  out  32  EX/MA register
- control_bus_out  out  24  EX/MA register

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset state: every registered output is 0; the FSM goes to IDLE; the divider state is cleared.
- Reset wins over every other event, including in the middle of a division: the division is abandoned and no result is written.
- ALU ops, 32-bit two's complement:
  - add, sub: wrap on overflow.
  - mul: signed, low 32 bits of the product.
  - lsl, lsr, asr: shift amount is op2[4:0].
  - not: ~op2. mov: op2. cmp: result = A-op2, for debug only.
  - No ALU bit set: result 0.
- Flags: updated only by cmp, at the clock edge ending its EX cycle. flag_e = (A==op2). flag_gt = signed(A)>signed(op2). Flags persist otherwise.
- Branch decision:
  - branch_taken = isUBranch | (isBeq & flag_e) | (isBgt & flag_gt), using the current flag registers.
  - branch_taken is forced to 0 while stall=1.
  - branch_pc = isRet ? A_in : btarget_in.
- Single-cycle ops: 1-cycle latency. The EX/MA register captures pc, instruction, result, B and control at the next edge.
- FSM states IDLE, DIV_RUN, DIV_DONE:
  - IDLE, div/mod at input, op2≠0: stall=1 combinationally in that cycle. Load |A| and |op2|, record the signs, count=0, go to DIV_RUN.
  - DIV_RUN: one restoring iteration per cycle, stall=1. When count=31 go to DIV_DONE.
  - DIV_DONE: stall=0. Sign-correct the result: quotient sign = sA^sB; remainder sign = sA. The EX/MA register captures the result. Go to IDLE.
- Division timing: total stall = 33 cycles; the div instruction occupies EX for 34 cycles.
- While stall=1, the EX/MA register loads a bubble: instruction_out=0, control_bus_out=0, other fields 0. Flags are unchanged.
- Divide by zero: no stall and single-cycle. div gives 32'hFFFFFFFF; mod gives A.
- 0x80000000 / -1: quotient 0x80000000, remainder 0, via the normal 33-cycle path.
- Back-to-back divs: the second div enters IDLE in the cycle after DIV_DONE and starts a new 33-cycle stall.

Optional Feature:
- Macro: EX_STALL_CNT_EN.
- Defined: adds output stall_cycles [31:0]. It increments on every cycle with stall=1, saturates at 32'hFFFFFFFF, and is cleared by reset.
- Not defined: the port and its counter do not exist; all other behaviour is identical.

Test Plan:
- Reset held 2 cycles, then released with a nop input → all outputs 0, stall=0, branch_taken=0.
- add A=0x7FFFFFFF, op2=1 → aluresult_out=0x80000000 one edge later; flags unchanged.
- cmp A=5, op2=5, then beq with btarget=0x40 in the next cycle → flag_e=1, flag_gt=0; in the beq cycle branch_taken=1 and branch_pc=0x40.
- div A=-7, op2=2 → stall high exactly 33 cycles, bubbles in EX/MA meanwhile, then aluresult_out=0xFFFFFFFD. Repeat with mod → 0xFFFFFFFF.
- div A=9, op2=0 → no stall, aluresult_out=0xFFFFFFFF next edge. mod A=9, op2=0 → 9.
- div A=100, op2=3, reset asserted in the 10th stall cycle → next edge all outputs 0 and stall=0. A following add executes normally.
